nibble_serial_addsub_seq: RTL

Sequential front-end that feeds a 4-bit add/subtract slice one nibble per clock to perform wide (4×NIBBLES-bit) addition or subtraction. It sits directly upstream of the 4-bit adder/subtractor datapath. It latches wide operands under a start handshake and sequences nibbles LSB-first, chaining carry between slices. It then presents the assembled result, final carry and signed overflow with a one-cycle done pulse. The slice arithmetic (a + b + ctl, or a + ~b + ctl) is instantiated inside this block.

---
 rtl/nibble_serial_addsub_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub_seq.sv
// rtl/nibble_serial_addsub_seq.sv - nibble-serial wide add/subtract sequencer around a 4-bit slice
// Optional signed-overflow logic is compiled in when NIBBLE_SEQ_OVERFLOW_EN is defined.
module nibble_serial_addsub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   control_in,
    output logic                   ready_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [4*NIBBLES-1:0]   result_out,
    output logic                   carry_out,
    output logic                   overflow_out
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  work;
    logic          ctl;
    logic          carry;
    logic [IW-1:0] idx;

    logic [3:0]    b_adj;
    logic [4:0]    slice_sum;
    logic [W-1:0]  next_work;

    // Operands shift right one nibble per cycle, so the slice always sees the current nibble
    // in bits [3:0]; the result nibble enters the work register at the top and settles LSB-first.
    always_comb begin
        b_adj     = b_sh[3:0] ^ {4{ctl}};
        slice_sum = {1'b0, a_sh[3:0]} + {1'b0, b_adj} + {4'b0, carry};
        next_work = {slice_sum[3:0], work[W-1:4]};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            ready_out    <= 1'b1;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            result_out   <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            a_sh         <= '0;
            b_sh         <= '0;
            work         <= '0;
            ctl          <= 1'b0;
            carry        <= 1'b0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        ctl       <= control_in;
                        carry     <= control_in;
                        idx       <= '0;
                        work      <= '0;
                        state     <= RUN;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    work  <= next_work;
                    carry <= slice_sum[4];
                    if (idx == LAST_IDX) begin
                        result_out <= next_work;
                        carry_out  <= slice_sum[4];
`ifdef NIBBLE_SEQ_OVERFLOW_EN
                        // carry into bit 3 of the MSB slice recovered from the sum bit
                        overflow_out <= slice_sum[4] ^ (a_sh[3] ^ b_adj[3] ^ slice_sum[3]);
`else
                        overflow_out <= 1'b0;
`endif
                        done_out   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_out  <= 1'b0;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                    done_out  <= 1'b0;
                end
            endcase
        end
    end
endmodule
